// File: rtl/sw_pwm_ctrl.sv
// Dead-time-protected complementary PWM generator driving sw1/sw2 of the switched-inductor model.
// Config is double-buffered and applied only on a period boundary or on run entry.
module sw_pwm_ctrl #(
  parameter int CNT_WIDTH  = 16,
  parameter int DEAD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CNT_WIDTH-1:0]  cfg_period,
  input  logic [CNT_WIDTH-1:0]  cfg_duty,
  input  logic [DEAD_WIDTH-1:0] cfg_dead,
  input  logic                  fault,
  output logic                  sw1,
  output logic                  sw2,
  output logic                  period_start,
  output logic                  fault_latched
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam int EXT_WIDTH = CNT_WIDTH + 1;

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]    per_q, per_d;
  logic [CNT_WIDTH-1:0]    duty_q, duty_d;
  logic [DEAD_WIDTH-1:0]   dead_q, dead_d;
  logic                    pend_full_q, pend_full_d;
  logic [CNT_WIDTH-1:0]    pend_per_q, pend_per_d;
  logic [CNT_WIDTH-1:0]    pend_duty_q, pend_duty_d;
  logic [DEAD_WIDTH-1:0]   pend_dead_q, pend_dead_d;
  logic                    sw1_q, sw1_d;
  logic                    sw2_q, sw2_d;
  logic                    pstart_q, pstart_d;
  logic                    flt_q, flt_d;

  logic                    run_stay;
  logic                    run_entry;
  logic                    at_end;
  logic                    apply_cfg;
  logic                    xfer;
  logic [CNT_WIDTH-1:0]    per_clamp;
  logic [CNT_WIDTH-1:0]    duty_clamp;
  logic [EXT_WIDTH-1:0]    c_ext;
  logic [EXT_WIDTH-1:0]    per_ext;
  logic [EXT_WIDTH-1:0]    duty_ext;
  logic [EXT_WIDTH-1:0]    dead_ext;
  logic [EXT_WIDTH-1:0]    sw2_start;
  logic                    sw1_win;
  logic                    sw2_win;

  // Fault wins over everything; leaving FAULT needs both fault and en low.
  always_comb begin
    state_d = state_q;
    if (fault) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE:  if (en)  state_d = ST_RUN;
        ST_RUN:   if (!en) state_d = ST_IDLE;
        ST_FAULT: if (!en) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  assign run_stay  = (state_q == ST_RUN)  && (state_d == ST_RUN);
  assign run_entry = (state_q == ST_IDLE) && (state_d == ST_RUN);
  assign at_end    = (cnt_q >= (per_q - CNT_WIDTH'(1)));
  assign apply_cfg = pend_full_q && ((run_stay && at_end) || run_entry);
  assign xfer      = cfg_valid && !pend_full_q;

  always_comb begin
    cnt_d = '0;
    if (run_stay) begin
      cnt_d = at_end ? '0 : (cnt_q + CNT_WIDTH'(1));
    end
  end

  // Clamp the pending values as they are applied so the active set is always sane.
  always_comb begin
    per_clamp  = (pend_per_q < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : pend_per_q;
    duty_clamp = (pend_duty_q > per_clamp) ? per_clamp : pend_duty_q;
  end

  always_comb begin
    pend_full_d = pend_full_q;
    pend_per_d  = pend_per_q;
    pend_duty_d = pend_duty_q;
    pend_dead_d = pend_dead_q;
    per_d       = per_q;
    duty_d      = duty_q;
    dead_d      = dead_q;
    if (xfer) begin
      pend_full_d = 1'b1;
      pend_per_d  = cfg_period;
      pend_duty_d = cfg_duty;
      pend_dead_d = cfg_dead;
    end else if (apply_cfg) begin
      pend_full_d = 1'b0;
      per_d       = per_clamp;
      duty_d      = duty_clamp;
      dead_d      = pend_dead_q;
    end
  end

  // Windows are compared one bit wider so D+DT cannot wrap into a false sw2 window.
  always_comb begin
    c_ext     = {1'b0, cnt_q};
    per_ext   = {1'b0, per_q};
    duty_ext  = {1'b0, duty_q};
    dead_ext  = {{(EXT_WIDTH - DEAD_WIDTH){1'b0}}, dead_q};
    sw2_start = duty_ext + dead_ext;
    sw1_win   = (c_ext >= dead_ext) && (c_ext < duty_ext);
    sw2_win   = (c_ext >= sw2_start) && (c_ext < per_ext);
  end

  always_comb begin
    sw1_d    = run_stay && sw1_win;
    sw2_d    = run_stay && sw2_win;
    pstart_d = run_stay && (cnt_q == '0);
    flt_d    = flt_q || (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      per_q       <= CNT_WIDTH'(2);
      duty_q      <= '0;
      dead_q      <= '0;
      pend_full_q <= 1'b0;
      pend_per_q  <= '0;
      pend_duty_q <= '0;
      pend_dead_q <= '0;
      sw1_q       <= 1'b0;
      sw2_q       <= 1'b0;
      pstart_q    <= 1'b0;
      flt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      per_q       <= per_d;
      duty_q      <= duty_d;
      dead_q      <= dead_d;
      pend_full_q <= pend_full_d;
      pend_per_q  <= pend_per_d;
      pend_duty_q <= pend_duty_d;
      pend_dead_q <= pend_dead_d;
      sw1_q       <= sw1_d;
      sw2_q       <= sw2_d;
      pstart_q    <= pstart_d;
      flt_q       <= flt_d;
    end
  end

  assign cfg_ready     = !pend_full_q;
  assign sw1           = sw1_q;
  assign sw2           = sw2_q;
  assign period_start  = pstart_q;
  assign fault_latched = flt_q;

endmodule

// File: tb/tb_sw_pwm_ctrl.sv
// Directed and randomized checks of sw_pwm_ctrl: waveforms, config timing, clamping,
// fault and reset behaviour, plus overlap and dead-gap invariants under random traffic.
module tb_sw_pwm_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_period = '0;
  logic [15:0] cfg_duty = '0;
  logic [7:0]  cfg_dead = '0;
  logic        fault = 1'b0;
  logic        sw1;
  logic        sw2;
  logic        period_start;
  logic        fault_latched;

  int errors = 0;
  int checks = 0;

  sw_pwm_ctrl #(.CNT_WIDTH(16), .DEAD_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_period    (cfg_period),
    .cfg_duty      (cfg_duty),
    .cfg_dead      (cfg_dead),
    .fault         (fault),
    .sw1           (sw1),
    .sw2           (sw2),
    .period_start  (period_start),
    .fault_latched (fault_latched)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Each step shows the outputs registered from counter value c; empty window when lo > hi.
  task automatic period_chk(input string tag, input int n, input int p, input int c0,
                            input int lo1, input int hi1, input int lo2, input int hi2);
    int c;
    c = c0;
    for (int k = 0; k < n; k++) begin
      step();
      chk({tag, "_pstart"}, period_start, (c == 0));
      chk({tag, "_sw1"}, sw1, (c >= lo1 && c <= hi1));
      chk({tag, "_sw2"}, sw2, (c >= lo2 && c <= hi2));
      c = (c + 1) % p;
    end
  endtask

  task automatic load_idle(input int p, input int d, input int dt);
    en = 1'b0;
    step();
    chk("idle_sw1", sw1, 0);
    chk("idle_sw2", sw2, 0);
    cfg_valid  = 1'b1;
    cfg_period = 16'(p);
    cfg_duty   = 16'(d);
    cfg_dead   = 8'(dt);
    step();
    cfg_valid = 1'b0;
    chk("load_ready_low", cfg_ready, 0);
    en = 1'b1;
    step();
    chk("entry_ready_high", cfg_ready, 1);
  endtask

  initial begin
    int last_hi;
    int low_run;
    int bound;
    logic prev_sw1;
    logic prev_sw2;

    // Reset state
    #1 rst = 1'b0;
    step();
    step();
    chk("rst_sw1", sw1, 0);
    chk("rst_sw2", sw2, 0);
    chk("rst_pstart", period_start, 0);
    chk("rst_fault_latched", fault_latched, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    rst = 1'b1;

    // Basic waveform P=10 D=5 DT=1
    load_idle(10, 5, 1);
    period_chk("p10d5", 30, 10, 0, 1, 4, 6, 9);

    // Mid-period update to P=10 D=8 DT=1
    period_chk("pre_upd", 3, 10, 0, 1, 4, 6, 9);
    chk("pre_upd_ready", cfg_ready, 1);
    cfg_valid  = 1'b1;
    cfg_period = 16'd10;
    cfg_duty   = 16'd8;
    cfg_dead   = 8'd1;
    period_chk("upd_xfer", 1, 10, 3, 1, 4, 6, 9);
    cfg_valid = 1'b0;
    chk("upd_ready_low", cfg_ready, 0);
    period_chk("upd_old", 5, 10, 4, 1, 4, 6, 9);
    chk("upd_ready_still_low", cfg_ready, 0);
    period_chk("upd_wrap", 1, 10, 9, 1, 4, 6, 9);
    chk("upd_ready_back", cfg_ready, 1);
    period_chk("p10d8", 20, 10, 0, 1, 7, 9, 9);

    // P=1 clamps to 2; D=0 DT=0 leaves sw1 off and sw2 on every cycle
    load_idle(1, 0, 0);
    period_chk("p1clamp", 6, 2, 0, 1, 0, 0, 1);

    // D=20 clamps to P=8; sw1 on 2..7, sw2 never
    load_idle(8, 20, 2);
    period_chk("dclamp", 16, 8, 0, 2, 7, 1, 0);

    // Fault at c=3 inside the sw1 window
    period_chk("pre_fault", 3, 8, 0, 2, 7, 1, 0);
    fault = 1'b1;
    step();
    chk("fault_sw1", sw1, 0);
    chk("fault_sw2", sw2, 0);
    chk("fault_latched", fault_latched, 1);
    fault = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("fault_hold_pstart", period_start, 0);
      chk("fault_hold_sw1", sw1, 0);
      chk("fault_hold_latched", fault_latched, 1);
    end
    en = 1'b0;
    step();
    chk("fault_exit_sw1", sw1, 0);
    en = 1'b1;
    step();
    period_chk("restart", 8, 8, 0, 2, 7, 1, 0);

    // Reset while sw2 high, with a config sitting in pending
    load_idle(10, 5, 1);
    period_chk("pre_rst", 8, 10, 0, 1, 4, 6, 9);
    cfg_valid  = 1'b1;
    cfg_period = 16'd6;
    cfg_duty   = 16'd3;
    cfg_dead   = 8'd0;
    period_chk("pre_rst_xfer", 1, 10, 8, 1, 4, 6, 9);
    cfg_valid = 1'b0;
    chk("pre_rst_ready", cfg_ready, 0);
    rst = 1'b0;
    #1;
    chk("arst_sw1", sw1, 0);
    chk("arst_sw2", sw2, 0);
    chk("arst_pstart", period_start, 0);
    chk("arst_ready", cfg_ready, 1);
    step();
    rst = 1'b1;
    step();
    period_chk("post_rst_default", 6, 2, 0, 1, 0, 0, 1);

    // Random traffic; DT per segment only decreases so the current one is a safe lower bound
    en = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    cfg_valid  = 1'b1;
    cfg_period = 16'd20;
    cfg_duty   = 16'd10;
    cfg_dead   = 8'd5;
    step();
    cfg_valid = 1'b0;
    last_hi  = 0;
    low_run  = 0;
    prev_sw1 = 1'b0;
    prev_sw2 = 1'b0;
    for (int seg = 0; seg < 4; seg++) begin
      bound = 5 - seg;
      for (int k = 0; k < 2500; k++) begin
        if ($urandom_range(99, 0) < 2) fault = ~fault;
        if ($urandom_range(99, 0) < 3) en = ~en;
        cfg_valid = ($urandom_range(2, 0) == 0);
        if ($urandom_range(9, 0) == 0) cfg_period = 16'($urandom_range(1, 0));
        else cfg_period = 16'($urandom_range(30, 2));
        cfg_duty = 16'($urandom_range(int'(cfg_period) + 4, 0));
        cfg_dead = 8'(bound);
        step();
        chk("rand_overlap", (sw1 && sw2), 0);
        if (sw1 && !prev_sw1 && last_hi == 2) chk("rand_gap21", (low_run >= bound), 1);
        if (sw2 && !prev_sw2 && last_hi == 1) chk("rand_gap12", (low_run >= bound), 1);
        if (sw1) begin
          last_hi = 1;
          low_run = 0;
        end else if (sw2) begin
          last_hi = 2;
          low_run = 0;
        end else begin
          low_run++;
        end
        prev_sw1 = sw1;
        prev_sw2 = sw2;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sw_pwm_ctrl.md
Name: sw_pwm_ctrl

Overview:
Dead-time-protected PWM controller that generates the complementary switch commands sw1/sw2 consumed by the switched-inductor circuit model under test. Duty, period and dead time come from a valid/ready config interface. New settings are double-buffered and take effect only at a period boundary, so the model never sees a glitch or a shoot-through pair (sw1 and sw2 high together). A fault input forces both switches open. Sits directly upstream of the circuit model in the same emulation clock domain.

Parameters:
CNT_WIDTH, 16, width of period and duty values and of the period counter
DEAD_WIDTH, 8, width of the dead-time value

Ports:
clk  input  1  emulation clock, rising-edge
rst  input  1  asynchronous, active-low reset
en  input  1  run enable
cfg_valid  input  1  config offer
cfg_ready  output  1  config accept ready
cfg_period  input  CNT_WIDTH  period P in clk cycles
cfg_duty  input  CNT_WIDTH  sw1 window end D
cfg_dead  input  DEAD_WIDTH  dead time DT in cycles
fault  input  1  fault request, level
sw1  output  1  high-side switch command to model
sw2  output  1  low-side switch command to model
period_start  output  1  one-cycle pulse, first cycle of each period
fault_latched  output  1  sticky fault indicator

Behaviour:
- Reset (rst=0, asynchronous): sw1=0, sw2=0, period_start=0, fault_latched=0, cfg_ready=1, cnt=0, state IDLE, pending empty. Active config resets to P=2, D=0, DT=0.
- States:
  - IDLE: outputs low, cnt held at 0.
  - RUN: counting.
  - FAULT: outputs low, fault_latched=1.
- Transitions:
  - IDLE->RUN when en=1 and fault=0. If pending is full, it is applied on entry.
  - RUN->IDLE when en=0.
  - any state->FAULT when fault=1. fault has priority over en and config.
  - FAULT->IDLE only when en=0 and fault=0.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready. The config goes into the pending register.
  - cfg_ready = !pending_full. It drops the cycle after a transfer.
  - Pending is applied, and cleared, when cnt wraps from P-1 to 0 in RUN, or on IDLE->RUN entry. cfg_ready rises the following cycle.
  - Transfer and apply in the same cycle cannot occur, because ready=0 whenever pending is full.
- Clamping on apply: P<2 is clamped to 2. D>P is clamped to P.
- Counter: in RUN, cnt increments and wraps to 0 at P-1.
- Switch windows, evaluated on the current cnt value c:
  - sw1_n = (c>=DT) && (c<D)
  - sw2_n = (c>=D+DT) && (c<P)
  - D+DT is computed at CNT_WIDTH+1 bits with no wrap.
  - D<=DT means sw1 is never on. D+DT>=P means sw2 is never on.
- Outputs sw1, sw2 and period_start (c==0) are registered: one-cycle latency from cnt. They are forced to 0 the cycle after entering IDLE or FAULT.
- Invariant: sw1 && sw2 never both 1 in any cycle. Between any sw1 falling and sw2 rising edge there are at least DT cycles with both low, and likewise between sw2 falling and sw1 rising.
- Reset mid-period: immediate return to the reset state. Pending and active config are both lost.

Test Plan:
- Reset, then cfg {P=10, D=5, DT=1}, en=1 -> sw1 high at c=1..4, sw2 high at c=6..9, repeating every 10 cycles; period_start pulses every 10 cycles; each output is observed one cycle after its c value.
- Mid-period accept of {P=10, D=8, DT=1} -> cfg_ready=0 until wrap; old waveform completes the current period; new waveform starts at the next c=0; cfg_ready returns to 1 one cycle after the wrap.
- Boundary configs:
  - {P=1, D=0, DT=0} -> runs as P=2 with sw1 never high.
  - {P=8, D=20, DT=2} -> D clamped to 8; sw1 high at c=2..7; sw2 never high.
- Assert fault at c=3 of a sw1 window -> sw1=0 next cycle, fault_latched=1; deasserting fault with en still 1 keeps state FAULT; en=0 returns to IDLE; en=1 restarts at c=0.
- Drop rst for one cycle while sw2 is high -> all outputs 0 asynchronously; active config back to P=2, D=0, DT=0; cfg_ready=1.
- Random configs and fault/en toggling over 10k cycles -> assertion checks that sw1&&sw2 is never true and the dead-gap length is at least DT.
